bcd_updown_counter: RTL and testbench
=====================================

Name: bcd_updown_counter

Overview:
- Cascaded synchronous BCD up/down counter.
- Produces a packed multi-digit decimal count.
- Sits directly upstream of the 4-line-to-10-line BCD decoder: its least-significant digit drives the decoder's 4-bit BCD input.
- Guarantees that only legal BCD codes (0-9) are ever presented downstream.

Parameters:
- DIGITS, 2, number of cascaded decade stages. Legal range 1-8.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = count up, 0 = count down.
- load  input  1  synchronous parallel load request.
- load_val  input  4*DIGITS  packed BCD load value; digit k is bits [4k+3:4k].
- q  output  4*DIGITS  packed BCD count; q[3:0] is the units digit and feeds the decoder.
- tc  output  1  terminal count / ripple carry, combinational.
- load_err  output  1  one-cycle registered pulse flagging a rejected load.

Behaviour:
- Reset, applied asynchronously while rst_n = 0:
  - q = 0.
  - load_err = 0.
  - tc follows from q = 0 and the current en/up inputs.
- Reset mid-count clears immediately and does not wait for a clock edge. The first count after release happens on the first rising edge with rst_n = 1.
- Per-edge priority: load > en > hold.
- Load (load = 1):
  - Every nibble of load_val must be <= 9 for the load to be legal.
  - Legal load: q <= load_val next edge; load_err <= 0.
  - Illegal load (any nibble 10-15): q holds its value; load_err <= 1 for exactly one cycle.
  - A load on the same edge as en = 1 suppresses the count. No count is applied to the loaded value that cycle.
- Count up (en = 1, up = 1, load = 0):
  - Digit 0 increments.
  - A digit at 9 wraps to 0 and increments the next digit.
  - A digit increments only when en = 1 and every lower digit = 9.
  - All digits at 9 wrap to all 0, i.e. modulo 10^DIGITS.
- Count down (en = 1, up = 0, load = 0):
  - Digit 0 decrements.
  - A digit at 0 wraps to 9 and borrows from the next digit.
  - All digits at 0 wrap to all 9.
- Hold (en = 0, load = 0): q unchanged. load_err <= 0 on every edge where no illegal load occurs.
- tc = en AND (up ? all digits = 9 : all digits = 0). It is combinational, for cascading a further counter's en.
- Direction change: up may change on any cycle. The new direction takes effect on the next edge, and tc re-evaluates combinationally.
- Latency: q updates one clock after a load or count request; tc has zero latency.
- Invariant: no nibble of q ever holds 10-15 outside reset.
- Arithmetic is per-nibble BCD. There is no binary add across the full vector.

Optional Feature:
- Macro: BCD_DECODE_EN.
- Defined:
  - Adds output port dec_n, 10 bits, active-low one-of-ten decode of q[3:0].
  - dec_n[d] = 0 when q[3:0] = d, all other bits 1.
  - Purely combinational from q, so dec_n = 10'b1111111110 during and after reset.
  - Lets a standalone board use the counter without the external decoder.
- Not defined: dec_n port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset: assert rst_n = 0 mid-count at q = 8'h47, between clock edges -> q = 8'h00 immediately (before next edge), load_err = 0. Release, en = 1, up = 1 -> q = 8'h01 after first edge.
2. Up wrap: load 8'h98, en = 1, up = 1 -> q sequence 98, 99, 00, 01. tc = 1 only while q = 99.
3. Down wrap: load 8'h01, en = 1, up = 0 -> q sequence 01, 00, 99, 98. tc = 1 only while q = 00. With en = 0 at q = 00 -> tc = 0.
4. Illegal load:
   - q = 8'h25, load = 1, load_val = 8'h3A -> q stays 25; load_err = 1 for one cycle, then 0.
   - load_val = 8'h37 -> q = 37, load_err = 0.
5. Priority and hold:
   - load = 1, en = 1, up = 1, load_val = 8'h50 -> q = 50, not 51.
   - en = 0 for 5 cycles -> q holds 50.
6. With BCD_DECODE_EN: load 8'h07 -> dec_n = 10'b1101111111. Count through 09 to 10 -> dec_n goes 10'b0111111111, then 10'b1111111110.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// Cascaded synchronous BCD up/down counter with parallel load and load validation.
// Optional BCD_DECODE_EN macro adds dec_n, an active-low one-of-ten decode of the units digit.
module bcd_updown_counter #(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
`ifdef BCD_DECODE_EN
    output logic                  load_err,
    output logic [9:0]            dec_n
`else
    output logic                  load_err
`endif
);

    logic [DIGITS-1:0]   is_nine;
    logic [DIGITS-1:0]   is_zero;
    logic [DIGITS-1:0]   is_term;
    logic [DIGITS-1:0]   step;
    logic [4*DIGITS-1:0] q_next;
    logic                load_ok;

    always_comb begin
        load_ok = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (load_val[4*k +: 4] > 4'd9) begin
                load_ok = 1'b0;
            end
        end
    end

    always_comb begin
        is_nine = '0;
        is_zero = '0;
        is_term = '0;
        for (int k = 0; k < DIGITS; k++) begin
            is_nine[k] = (q[4*k +: 4] == 4'd9);
            is_zero[k] = (q[4*k +: 4] == 4'd0);
            is_term[k] = up ? is_nine[k] : is_zero[k];
        end
    end

    // A digit steps only when every lower digit sits at its terminal value;
    // computed per digit from is_term so there is no combinational chain feedback.
    always_comb begin
        logic lower_term;
        step = '0;
        for (int k = 0; k < DIGITS; k++) begin
            lower_term = 1'b1;
            for (int j = 0; j < k; j++) begin
                lower_term = lower_term & is_term[j];
            end
            step[k] = en & lower_term;
        end
    end

    always_comb begin
        q_next = q;
        for (int k = 0; k < DIGITS; k++) begin
            if (step[k]) begin
                if (up) begin
                    q_next[4*k +: 4] = is_nine[k] ? 4'd0 : (q[4*k +: 4] + 4'd1);
                end else begin
                    q_next[4*k +: 4] = is_zero[k] ? 4'd9 : (q[4*k +: 4] - 4'd1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q        <= '0;
            load_err <= 1'b0;
        end else if (load) begin
            if (load_ok) begin
                q        <= load_val;
                load_err <= 1'b0;
            end else begin
                load_err <= 1'b1;
            end
        end else begin
            load_err <= 1'b0;
            if (en) begin
                q <= q_next;
            end
        end
    end

    assign tc = en & (up ? (&is_nine) : (&is_zero));

`ifdef BCD_DECODE_EN
    always_comb begin
        dec_n = '1;
        for (int d = 0; d < 10; d++) begin
            if (q[3:0] == 4'(d)) begin
                dec_n[d] = 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed, table-driven bench for bcd_updown_counter (DIGITS = 2).
module tb_bcd_updown_counter;

    localparam int DIGITS = 2;

    logic                clk;
    logic                rst_n;
    logic                en;
    logic                up;
    logic                load;
    logic [4*DIGITS-1:0] load_val;
    logic [4*DIGITS-1:0] q;
    logic                tc;
    logic                load_err;
`ifdef BCD_DECODE_EN
    logic [9:0]          dec_n;
`endif

    int checks;
    int failures;

    bcd_updown_counter #(.DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .tc       (tc),
`ifdef BCD_DECODE_EN
        .load_err (load_err),
        .dec_n    (dec_n)
`else
        .load_err (load_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       load;
        logic       en;
        logic       up;
        logic [7:0] load_val;
        logic [7:0] exp_q;
        logic       exp_tc;
        logic       exp_err;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    initial begin
        int m;
        checks   = 0;
        failures = 0;

        //            load  en    up    lval   q      tc    err
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 8'h98, 8'h98, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h99, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h01, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 8'h01, 8'h01, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h99, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h98, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 8'h25, 8'h25, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 8'h3A, 8'h25, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h3A, 8'h25, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 8'h37, 8'h37, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 8'h50, 8'h50, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h50, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h50, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h50, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h50, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h50, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b1, 1'b1, 8'hA0, 8'h50, 1'b0, 1'b1};
        vecs[19] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};

        rst_n    = 1'b0;
        en       = 1'b0;
        up       = 1'b1;
        load     = 1'b0;
        load_val = '0;
        #12;
        chk("reset_q", 32'(q), 32'h00);
        chk("reset_err", 32'(load_err), 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            load     = vecs[i].load;
            en       = vecs[i].en;
            up       = vecs[i].up;
            load_val = vecs[i].load_val;
            tick();
            chk($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].exp_q));
            chk($sformatf("vec%0d_tc", i), 32'(tc), 32'(vecs[i].exp_tc));
            chk($sformatf("vec%0d_err", i), 32'(load_err), 32'(vecs[i].exp_err));
        end

        // tc is combinational: dropping en at q = 00 clears it without an edge
        load = 1'b0;
        en   = 1'b0;
        #1;
        chk("tc_en_low", 32'(tc), 32'h0);
        en = 1'b1;
        up = 1'b1;
        #1;
        chk("tc_dir_up_at_00", 32'(tc), 32'h0);
        up = 1'b0;
        #1;
        chk("tc_dir_down_at_00", 32'(tc), 32'h1);

        // Asynchronous reset in the middle of a cycle
        en       = 1'b0;
        load     = 1'b1;
        load_val = 8'h47;
        tick();
        load = 1'b0;
        chk("pre_reset_q", 32'(q), 32'h47);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_q", 32'(q), 32'h00);
        chk("async_reset_err", 32'(load_err), 32'h0);
        en = 1'b1;
        up = 1'b0;
        #1;
        chk("reset_tc_down", 32'(tc), 32'h1);
        up = 1'b1;
        #1;
        rst_n = 1'b1;
        tick();
        chk("first_count_after_reset", 32'(q), 32'h01);

        // Long up run against a decimal model, through the 99 -> 00 wrap
        m = 1;
        for (int i = 0; i < 120; i++) begin
            tick();
            m = (m + 1) % 100;
            chk($sformatf("up_run%0d_q", i), 32'(q), 32'(to_bcd(m)));
            chk($sformatf("up_run%0d_tc", i), 32'(tc), 32'(m == 99));
        end

        // Long down run, through the 00 -> 99 wrap
        up = 1'b0;
        for (int i = 0; i < 120; i++) begin
            tick();
            m = (m + 99) % 100;
            chk($sformatf("dn_run%0d_q", i), 32'(q), 32'(to_bcd(m)));
            chk($sformatf("dn_run%0d_tc", i), 32'(tc), 32'(m == 0));
        end

        // load_err must be a single-cycle pulse even if the bad load is held off after one edge
        en       = 1'b0;
        load     = 1'b1;
        load_val = 8'hF9;
        tick();
        chk("bad_hi_q", 32'(q), 32'(to_bcd(m)));
        chk("bad_hi_err", 32'(load_err), 32'h1);
        load = 1'b0;
        tick();
        chk("bad_hi_err_clear", 32'(load_err), 32'h0);

`ifdef BCD_DECODE_EN
        load     = 1'b1;
        load_val = 8'h07;
        tick();
        load = 1'b0;
        chk("dec_07", 32'(dec_n), 32'(10'b1101111111));
        en = 1'b1;
        up = 1'b1;
        tick();
        chk("dec_08", 32'(dec_n), 32'(10'b1011111111));
        tick();
        chk("dec_09", 32'(dec_n), 32'(10'b0111111111));
        tick();
        chk("dec_10_q", 32'(q), 32'h10);
        chk("dec_10", 32'(dec_n), 32'(10'b1111111110));
        #2;
        rst_n = 1'b0;
        #1;
        chk("dec_reset", 32'(dec_n), 32'(10'b1111111110));
        rst_n = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
